biquad_seq_ctrl: RTL and testbench

- Moore sequencer for the shared single-MAC datapath of the second-order IIR (biquad) section: result = muxS*muxC + muxZ.
- Sequences the coefficient, state and addend selectors of the mux block, one MAC step at a time, and pulses the register-load enables.
- One filter sample per start strike: Direct Form II.
  - fk = Uk + a1*fk1 + a2*fk2
  - yk = b0*fk + b1*fk1 + b2*fk2
- Sits between the sample-rate tick generator and the datapath registers (acum1..3, fk, fk1, fk2, yk).

---
 rtl/biquad_seq_ctrl_pkg.sv | 65 ++++++
 rtl/biquad_seq_ctrl.sv | 77 +++++++
 tb/tb_biquad_seq_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/biquad_seq_ctrl_pkg.sv
// Shared codes for the biquad MAC sequencer: mux selector encodings, FSM states
// and the per-state control word decode.
package biquad_seq_ctrl_pkg;

  localparam logic [2:0] SEL_CERO = 3'd0;
  localparam logic [2:0] SEL_A1   = 3'd1;
  localparam logic [2:0] SEL_A2   = 3'd2;
  localparam logic [2:0] SEL_B0   = 3'd3;
  localparam logic [2:0] SEL_B1   = 3'd4;
  localparam logic [2:0] SEL_B2   = 3'd5;

  localparam logic [1:0] C_CERO   = 2'd0;
  localparam logic [1:0] C_FK1    = 2'd1;
  localparam logic [1:0] C_FK2    = 2'd2;
  localparam logic [1:0] C_FK     = 2'd3;

  localparam logic [2:0] Z_CERO   = 3'd0;
  localparam logic [2:0] Z_UK     = 3'd1;
  localparam logic [2:0] Z_YK     = 3'd2;
  localparam logic [2:0] Z_ACUM1  = 3'd3;
  localparam logic [2:0] Z_ACUM2  = 3'd4;
  localparam logic [2:0] Z_ACUM3  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M1   = 3'd1,
    ST_M2   = 3'd2,
    ST_M3   = 3'd3,
    ST_M4   = 3'd4,
    ST_M5   = 3'd5,
    ST_UPD  = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] sel_s;
    logic [1:0] sel_c;
    logic [2:0] sel_z;
    logic       ld_acum1;
    logic       ld_acum2;
    logic       ld_acum3;
    logic       ld_fk;
    logic       ld_yk;
    logic       shift_en;
    logic       busy;
    logic       done;
  } ctrl_t;

  // last: final hold cycle of a MAC step, the only cycle its load may fire
  function automatic ctrl_t decode(state_t st, logic last);
    ctrl_t c;
    c = '0;
    case (st)
      ST_M1: begin c.sel_s = SEL_A1; c.sel_c = C_FK1;  c.sel_z = Z_UK;    c.ld_acum1 = last; end
      ST_M2: begin c.sel_s = SEL_A2; c.sel_c = C_FK2;  c.sel_z = Z_ACUM1; c.ld_fk    = last; end
      ST_M3: begin c.sel_s = SEL_B0; c.sel_c = C_FK;   c.sel_z = Z_CERO;  c.ld_acum2 = last; end
      ST_M4: begin c.sel_s = SEL_B1; c.sel_c = C_FK1;  c.sel_z = Z_ACUM2; c.ld_acum3 = last; end
      ST_M5: begin c.sel_s = SEL_B2; c.sel_c = C_FK2;  c.sel_z = Z_ACUM3; c.ld_yk    = last; end
      ST_UPD: begin c.shift_en = 1'b1; c.done = 1'b1; end
      default: ;
    endcase
    c.busy = (st != ST_IDLE);
    return c;
  endfunction

endpackage

// File: rtl/biquad_seq_ctrl.sv
// Moore sequencer for the single-MAC Direct Form II biquad: five MAC steps of
// MAC_LAT cycles each, then one delay-line update cycle.
module biquad_seq_ctrl
  import biquad_seq_ctrl_pkg::*;
#(
  parameter int MAC_LAT = 1,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       clr_ovf,
  output logic [2:0] controlS,
  output logic [1:0] controlC,
  output logic [2:0] controlZ,
  output logic       ld_acum1,
  output logic       ld_acum2,
  output logic       ld_acum3,
  output logic       ld_fk,
  output logic       ld_yk,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  localparam logic [CW-1:0] LAST = CW'(MAC_LAT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  ctrl_t         ctrl_q, ctrl_n;

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      ST_IDLE: if (start) state_n = ST_M1;
      ST_M1:   if (cnt == LAST) state_n = ST_M2; else cnt_n = cnt + 1'b1;
      ST_M2:   if (cnt == LAST) state_n = ST_M3; else cnt_n = cnt + 1'b1;
      ST_M3:   if (cnt == LAST) state_n = ST_M4; else cnt_n = cnt + 1'b1;
      ST_M4:   if (cnt == LAST) state_n = ST_M5; else cnt_n = cnt + 1'b1;
      ST_M5:   if (cnt == LAST) state_n = ST_UPD; else cnt_n = cnt + 1'b1;
      default: state_n = ST_IDLE;
    endcase
    // outputs are registered from the next state so they track state/cnt exactly
    ctrl_n = decode(state_n, cnt_n == LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ctrl_q <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ctrl_q <= ctrl_n;
      // an overrun in the same cycle as a clear keeps the flag set
      if (start && state != ST_IDLE) ovf <= 1'b1;
      else if (clr_ovf)              ovf <= 1'b0;
    end
  end

  assign controlS = ctrl_q.sel_s;
  assign controlC = ctrl_q.sel_c;
  assign controlZ = ctrl_q.sel_z;
  assign ld_acum1 = ctrl_q.ld_acum1;
  assign ld_acum2 = ctrl_q.ld_acum2;
  assign ld_acum3 = ctrl_q.ld_acum3;
  assign ld_fk    = ctrl_q.ld_fk;
  assign ld_yk    = ctrl_q.ld_yk;
  assign shift_en = ctrl_q.shift_en;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// Directed bench for biquad_seq_ctrl: MAC_LAT=1 and MAC_LAT=3 instances, with a
// behavioural Q14 datapath on the MAC_LAT=1 instance for an impulse-response run.
module tb_biquad_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start1 = 1'b0, clr1 = 1'b0, start3 = 1'b0, clr3 = 1'b0;
  logic [2:0] s1, z1, s3, z3;
  logic [1:0] c1, c3;
  wire  [7:0] f1, f3;
  logic ovf1, ovf3;
  wire  [15:0] vec1 = {s1, c1, z1, f1};
  wire  [15:0] vec3 = {s3, c3, z3, f3};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  biquad_seq_ctrl #(.MAC_LAT(1), .CW(4)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .clr_ovf(clr1),
    .controlS(s1), .controlC(c1), .controlZ(z1),
    .ld_acum1(f1[7]), .ld_acum2(f1[6]), .ld_acum3(f1[5]), .ld_fk(f1[4]), .ld_yk(f1[3]),
    .shift_en(f1[2]), .busy(f1[1]), .done(f1[0]), .ovf(ovf1));

  biquad_seq_ctrl #(.MAC_LAT(3), .CW(4)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .clr_ovf(clr3),
    .controlS(s3), .controlC(c3), .controlZ(z3),
    .ld_acum1(f3[7]), .ld_acum2(f3[6]), .ld_acum3(f3[5]), .ld_fk(f3[4]), .ld_yk(f3[3]),
    .shift_en(f3[2]), .busy(f3[1]), .done(f3[0]), .ovf(ovf3));

  // expected {S,C,Z,ld_acum1,ld_acum2,ld_acum3,ld_fk,ld_yk,shift_en,busy,done}
  function automatic logic [15:0] exp_of(int k);
    case (k)
      0: return 16'h2982;
      1: return 16'h5312;
      2: return 16'h7842;
      3: return 16'h8C22;
      4: return 16'hB50A;
      5: return 16'h0007;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // MAC_LAT=1 run; caller sits at a negedge. Inputs set at step k are sampled
  // at the edge closing that step.
  task automatic seq1(input string tag, input int ovr_a, input int ovr_b, input int clr_k);
    start1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("%s_s%0d", tag, k), 32'(vec1), 32'(exp_of(k)));
      start1 = (k == ovr_a || k == ovr_b);
      clr1   = (k == clr_k);
    end
    @(negedge clk);
    start1 = 1'b0;
    clr1   = 1'b0;
    chk($sformatf("%s_idle", tag), 32'(vec1), 32'h0);
  endtask

  task automatic seq3(input string tag);
    logic [15:0] e;
    start3 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      e = exp_of(k / 3);
      if (k < 15 && (k % 3) != 2) e = e & 16'hFF07;
      chk($sformatf("%s_s%0d", tag, k), 32'(vec3), 32'(e));
    end
    @(negedge clk);
    chk($sformatf("%s_idle", tag), 32'(vec3), 32'h0);
  endtask

  // behavioural Q14 datapath driven by u1
  int uk = 0, acum1 = 0, acum2 = 0, acum3 = 0, fk = 0, fk1 = 0, fk2 = 0, yk = 0;
  int coef, st, add, res;
  int dcount = 0;

  always_comb begin
    case (s1)
      3'd1: coef = 32112;
      3'd2: coef = -15736;
      3'd3: coef = 16384;
      3'd4: coef = -32768;
      3'd5: coef = 16384;
      default: coef = 0;
    endcase
    case (c1)
      2'd1: st = fk1;
      2'd2: st = fk2;
      2'd3: st = fk;
      default: st = 0;
    endcase
    case (z1)
      3'd1: add = uk;
      3'd2: add = yk;
      3'd3: add = acum1;
      3'd4: add = acum2;
      3'd5: add = acum3;
      default: add = 0;
    endcase
    res = int'((longint'(coef) * longint'(st)) >>> 14) + add;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acum1 <= 0; acum2 <= 0; acum3 <= 0; fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0;
    end else begin
      if (f1[7]) acum1 <= res;
      if (f1[6]) acum2 <= res;
      if (f1[5]) acum3 <= res;
      if (f1[4]) fk <= res;
      if (f1[3]) yk <= res;
      if (f1[2]) begin fk2 <= fk1; fk1 <= fk; end
    end
  end

  always @(posedge clk) if (f1[0]) dcount <= dcount + 1;

  function automatic longint q14(longint c, longint x);
    return (c * x) >>> 14;
  endfunction

  initial begin
    longint rf1, rf2, rfk, ry;
    int d0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_vec1", 32'(vec1), 32'h0);
    chk("rst_vec3", 32'(vec3), 32'h0);
    chk("rst_ovf", {30'd0, ovf1, ovf3}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // single sample, one cycle per MAC step
    seq1("t1", -1, -1, -1);
    chk("t1_ovf", 32'(ovf1), 32'h0);

    // three cycles per MAC step
    seq3("t2");

    // overrun during M3 and during UPD
    seq1("t3ovr", 2, 5, -1);
    chk("t3_ovf_set", 32'(ovf1), 32'h1);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("t3_ovf_clr", 32'(ovf1), 32'h0);
    seq1("t3coin", 1, -1, 1);
    chk("t3_ovf_coin", 32'(ovf1), 32'h1);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("t3_ovf_clr2", 32'(ovf1), 32'h0);

    // reset asserted in the first M4 cycle of the MAC_LAT=3 instance
    start3 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start3 = 1'b0;
    end
    chk("t4_m4", 32'(vec3), 32'(exp_of(3) & 16'hFF07));
    reset_n = 1'b0;
    #1;
    chk("t4_rst_now", 32'(vec3), 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("t4_hold%0d", k), 32'(vec3), 32'h0);
    end
    // start held across release is taken on the first edge
    start3 = 1'b1;
    reset_n = 1'b1;
    seq3("t4run");

    // impulse response, starts every 7 cycles (6 busy + 1 idle)
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    d0 = dcount;
    rf1 = 0; rf2 = 0;
    for (int n = 0; n < 200; n++) begin
      uk = (n == 0) ? 16384 : 0;
      rfk = longint'(uk) + q14(32112, rf1) + q14(-15736, rf2);
      ry  = q14(16384, rfk) + q14(-32768, rf1) + q14(16384, rf2);
      rf2 = rf1;
      rf1 = rfk;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (5) @(negedge clk);
      if (n < 3 || n == 199) chk($sformatf("t5_done%0d", n), 32'(f1[0]), 32'h1);
      chk($sformatf("t5_yk%0d", n), 32'(yk), 32'(ry));
      @(negedge clk);
    end
    chk("t6_ovf", 32'(ovf1), 32'h0);
    chk("t6_dones", 32'(dcount - d0), 32'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
